add_sub_bist: RTL and testbench
===============================

Name: add_sub_bist

Overview:
Self-test initiator for the team's add_sub adder/subtractor. It drives the exhaustive operand/mode space onto add_sub's a/b/mode inputs and samples Sum/Cout back. Each response is compared against an internal golden model, and the block reports pass/fail, an error count and the first failing vector. It sits beside add_sub as its stimulus/checking partner, both in silicon BIST and in the bench.

Parameters:
WIDTH, 4, operand width; must match the attached add_sub.
SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal values are 1 or more.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to run; sampled only in IDLE or DONE
dut_a  output  WIDTH  operand a to add_sub
dut_b  output  WIDTH  operand b to add_sub
dut_mode  output  1  0 = add, 1 = subtract
dut_sum  input  WIDTH  add_sub Sum
dut_cout  input  1  add_sub Cout
busy  output  1  run in progress
done  output  1  run complete; held until next start or rst
pass  output  1  valid when done; 1 iff err_count == 0
err_count  output  2*WIDTH+1  mismatching vectors, saturating at all-ones
first_fail_vec  output  2*WIDTH+1  {mode, b, a} of the first mismatch; 0 if none

Behaviour:
- Vector register vec, 2*WIDTH+1 bits, decomposed as dut_a = vec[WIDTH-1:0], dut_b = vec[2W-1:W], dut_mode = vec[2W].
  - a varies fastest, then b, then mode.
  - Outputs come directly from registers, with no combinational path from inputs.
- Golden model:
  - Add: {cout, sum} = a + b.
  - Subtract: {cout, sum} = a + ~b + 1. cout = 1 means no borrow (a >= b).
  - Truncation is to WIDTH bits.
  - Mismatch = sum or cout differs from the model.
- Reset: state IDLE, and vec, settle_cnt, busy, done, pass, err_count and first_fail_vec are all 0. Reset mid-run aborts immediately with no partial result retained.
- FSM states are IDLE, SETTLE, CHECK and DONE.
  - IDLE/DONE with start=1: vec <= 0, settle_cnt <= 0, err_count <= 0, first_fail_vec <= 0, done <= 0, pass <= 0, busy <= 1; go to SETTLE.
  - SETTLE: if settle_cnt == SETTLE_CYCLES-1, go to CHECK; otherwise settle_cnt++.
  - CHECK: compare.
    - On mismatch, err_count++ (saturating), and first_fail_vec <= vec if err_count was 0.
    - If vec is all-ones, go to DONE: busy <= 0, done <= 1, pass <= (no mismatch in the run, including this CHECK).
    - Otherwise vec++, settle_cnt <= 0, go to SETTLE.
  - DONE: hold all results and keep dut_* at the last vector.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. With WIDTH=4 and SETTLE=1, done rises exactly 1024 cycles after the edge that samples start.
- start while busy is ignored. start in DONE restarts the run and clears the results.
- Saturation: err_count never wraps. It is sized to hold 2^(2W+1)-1; the final vector's error saturates at all-ones.
- dut_* inputs are sampled only in CHECK, and X/changes in other states are don't-care.

Decomposition:
- Shared package add_sub_pkg:
  - WIDTH default
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - vector field offsets
- One sub-module add_sub_golden: combinational expected {cout, sum} from (a, b, mode). It is reused by the bench scoreboard.
- The FSM, counters and comparator stay in add_sub_bist.

Test Plan:
- Healthy add_sub attached, rst then start pulse -> busy for 1024 cycles, then done=1, pass=1, err_count=0, first_fail_vec=0. Spot checks during the run:
  - vec {0,0010,0110}: sum 1000, cout 0.
  - vec {0,0001,1111}: sum 0000, cout 1.
  - vec {1,0011,1001}: sum 0110, cout 1.
  - vec {1,1100,1001}: sum 1101, cout 0.
- Cout stuck-at-0 model -> done, pass=0, err_count=256 (120 add carries + 136 subtracts with a>=b), first_fail_vec=9'h01F.
- Sum[0] stuck-at-0 model -> err_count=256, first_fail_vec=9'h001.
- Healthy model, rst asserted for 1 cycle at cycle 300 of the run -> next cycle is IDLE with all outputs 0. A following start completes with pass=1 at +1024 cycles.
- start pulsed repeatedly while busy -> no effect, done still at cycle 1024. start pulsed in DONE -> done and pass clear next cycle and the run repeats.
- SETTLE_CYCLES=3 instance with a model whose outputs are registered by 2 cycles -> pass=1, done at 2048 cycles.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add_sub self-test: default operand width,
// BIST controller states and the layout of the {mode, b, a} test vector.
package add_sub_pkg;

  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Test vector layout: a in the low bits, b above it, mode on top.
  localparam int A_OFS = 0;

  function automatic int b_ofs(input int w);
    return w;
  endfunction

  function automatic int mode_ofs(input int w);
    return 2 * w;
  endfunction

  function automatic int vec_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/add_sub_golden.sv
// Reference model of the add_sub adder/subtractor.
// Ports:
//   a, b  : DATA_W-bit operands
//   mode  : 0 = add, 1 = subtract
//   sum   : DATA_W-bit truncated result
//   cout  : carry out; in subtract mode 1 means no borrow (a >= b)
module add_sub_golden
  import add_sub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   total;

  // Subtract is a + ~b + 1, so the carry-in is simply the mode bit.
  always_comb begin
    b_op  = mode ? ~b : b;
    total = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, mode};
  end

  assign sum  = total[DATA_W-1:0];
  assign cout = total[DATA_W];

endmodule

// File: rtl/add_sub_bist.sv
// Self-test initiator for add_sub. Walks every {mode, b, a} combination,
// holds each for SETTLE_CYCLES cycles, then compares add_sub's response
// against add_sub_golden and accumulates the result.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle run request (honoured in IDLE or DONE)
//   dut_a/b/mode      : registered stimulus to add_sub
//   dut_sum/cout      : add_sub response, sampled only in CHECK
//   busy, done, pass  : run status; pass valid while done
//   err_count         : mismatching vectors, saturating
//   first_fail_vec    : {mode, b, a} of the first mismatch, 0 if none
module add_sub_bist
  import add_sub_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [DATA_W-1:0]     dut_a,
  output logic [DATA_W-1:0]     dut_b,
  output logic                  dut_mode,
  input  logic [DATA_W-1:0]     dut_sum,
  input  logic                  dut_cout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*DATA_W:0]     err_count,
  output logic [2*DATA_W:0]     first_fail_vec
);

  localparam int VEC_W    = vec_w(DATA_W);
  localparam int B_OFS    = b_ofs(DATA_W);
  localparam int MODE_OFS = mode_ofs(DATA_W);
  localparam int CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   vec, vec_nxt;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic               busy_nxt, done_nxt, pass_nxt;
  logic [VEC_W-1:0]   err_nxt, ffv_nxt;
  logic [DATA_W-1:0]  exp_sum;
  logic               exp_cout;
  logic               mismatch;

  function automatic logic [VEC_W-1:0] sat_inc(input logic [VEC_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  assign dut_a    = vec[A_OFS +: DATA_W];
  assign dut_b    = vec[B_OFS +: DATA_W];
  assign dut_mode = vec[MODE_OFS];

  add_sub_golden #(
    .DATA_W (DATA_W)
  ) u_golden (
    .a    (dut_a),
    .b    (dut_b),
    .mode (dut_mode),
    .sum  (exp_sum),
    .cout (exp_cout)
  );

  assign mismatch = (dut_sum != exp_sum) || (dut_cout != exp_cout);

  // ---- next-state / result update ----
  always_comb begin
    state_nxt      = state;
    vec_nxt        = vec;
    settle_cnt_nxt = settle_cnt;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    err_nxt        = err_count;
    ffv_nxt        = first_fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          vec_nxt        = '0;
          settle_cnt_nxt = '0;
          err_nxt        = '0;
          ffv_nxt        = '0;
          done_nxt       = 1'b0;
          pass_nxt       = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = CHECK;
        end else begin
          settle_cnt_nxt = settle_cnt + 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_nxt = sat_inc(err_count);
          if (err_count == '0) begin
            ffv_nxt = vec;
          end
        end
        if (&vec) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          // err_count saturates, so zero here really means no earlier miss.
          pass_nxt  = (err_count == '0) && !mismatch;
        end else begin
          vec_nxt        = vec + 1'b1;
          settle_cnt_nxt = '0;
          state_nxt      = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- state registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= '0;
      settle_cnt     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else begin
      state          <= state_nxt;
      vec            <= vec_nxt;
      settle_cnt     <= settle_cnt_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      err_count      <= err_nxt;
      first_fail_vec <= ffv_nxt;
    end
  end

endmodule

// File: tb/tb_add_sub_bist.sv
// Directed bench for add_sub_bist: a behavioural add_sub with selectable
// faults is attached to a SETTLE_CYCLES=1 instance, and a two-register
// delayed healthy add_sub to a SETTLE_CYCLES=3 instance.
module tb_add_sub_bist;
  import add_sub_pkg::*;

  localparam int W  = DATA_W_DEF;
  localparam int VW = 2 * W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, start3;
  logic [W-1:0]  dut_a, dut_b, dut_sum;
  logic          dut_mode, dut_cout, busy, done, pass;
  logic [VW-1:0] err_count, first_fail_vec;

  logic [W-1:0]  dut_a3, dut_b3, dut_sum3;
  logic          dut_mode3, dut_cout3, busy3, done3, pass3;
  logic [VW-1:0] err_count3, first_fail_vec3;

  logic [W-1:0]  g_sum;
  logic          g_cout;

  int fault;
  int checks = 0;
  int errors = 0;

  add_sub_bist #(.DATA_W(W), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_mode(dut_mode),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_vec(first_fail_vec)
  );

  add_sub_bist #(.DATA_W(W), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .dut_a(dut_a3), .dut_b(dut_b3), .dut_mode(dut_mode3),
    .dut_sum(dut_sum3), .dut_cout(dut_cout3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .first_fail_vec(first_fail_vec3)
  );

  add_sub_golden #(.DATA_W(W)) u_ref (
    .a(dut_a), .b(dut_b), .mode(dut_mode), .sum(g_sum), .cout(g_cout)
  );

  // Behavioural add_sub written as add / borrow-subtract, with faults:
  // 1 = cout stuck at 0, 2 = sum[0] stuck at 0.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic mode, input int f);
    logic [W-1:0] s;
    logic         c;
    if (!mode) begin
      {c, s} = {1'b0, a} + {1'b0, b};
    end else begin
      s = a - b;
      c = (a >= b);
    end
    if (f == 1) c = 1'b0;
    if (f == 2) s[0] = 1'b0;
    return {c, s};
  endfunction

  assign {dut_cout, dut_sum} = model(dut_a, dut_b, dut_mode, fault);

  logic [W:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= model(dut_a3, dut_b3, dut_mode3, 0);
    pipe2 <= pipe1;
  end
  assign {dut_cout3, dut_sum3} = pipe2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Spot vectors {mode,b,a} and hand-computed {cout,sum}.
  logic [VW-1:0] spot_vec [4] = '{9'h026, 9'h01F, 9'h139, 9'h1C9};
  logic [W:0]    spot_exp [4] = '{5'b0_1000, 5'b1_0000, 5'b1_0110, 5'b0_1101};
  bit            spot_seen[4] = '{0, 0, 0, 0};
  bit            spot_en = 1'b0;

  always @(negedge clk) begin
    if (spot_en) begin
      for (int i = 0; i < 4; i++) begin
        if (!spot_seen[i] && ({dut_mode, dut_b, dut_a} == spot_vec[i])) begin
          spot_seen[i] <= 1'b1;
          chk($sformatf("spot%0d_model", i), {27'd0, dut_cout, dut_sum}, {27'd0, spot_exp[i]});
          chk($sformatf("spot%0d_golden", i), {27'd0, g_cout, g_sum}, {27'd0, spot_exp[i]});
        end
      end
    end
  end

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start3 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  // Called right after pulse_start; returns edges from the start-sampling
  // edge to the edge that raised done.
  task automatic wait_done(input bit sel, input bit spam, input int limit, output int lat);
    int c = 1;
    while (!(sel ? done3 : done) && c < limit) begin
      start = spam && (c % 97 == 0);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    lat   = c - 1;
  endtask

  initial begin
    int lat;
    int seen;
    rst    = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    fault  = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffv", first_fail_vec, 0);
    chk("rst_vec", {dut_mode, dut_b, dut_a}, 0);
    chk("rst_done3", done3, 0);
    rst = 1'b0;

    // Healthy run with spot checks.
    spot_en = 1'b1;
    pulse_start(0);
    chk("busy_after_start", busy, 1);
    wait_done(0, 0, 1100, lat);
    spot_en = 1'b0;
    chk("healthy_latency", lat, 1024);
    chk("healthy_pass", pass, 1);
    chk("healthy_err", err_count, 0);
    chk("healthy_ffv", first_fail_vec, 0);
    chk("healthy_busy_end", busy, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) seen += spot_seen[i];
    chk("spot_seen", seen, 4);

    // Results held in DONE.
    repeat (5) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_pass", pass, 1);
    chk("hold_vec", {dut_mode, dut_b, dut_a}, 9'h1FF);

    // Restart from DONE, with start spammed while busy.
    pulse_start(0);
    chk("restart_done_clr", done, 0);
    chk("restart_pass_clr", pass, 0);
    chk("restart_busy", busy, 1);
    wait_done(0, 1, 1100, lat);
    chk("spam_latency", lat, 1024);
    chk("spam_pass", pass, 1);

    // Cout stuck at 0.
    fault = 1;
    pulse_start(0);
    wait_done(0, 0, 1100, lat);
    chk("cout_sa0_latency", lat, 1024);
    chk("cout_sa0_pass", pass, 0);
    chk("cout_sa0_err", err_count, 256);
    chk("cout_sa0_ffv", first_fail_vec, 9'h01F);

    // Sum[0] stuck at 0.
    fault = 2;
    pulse_start(0);
    wait_done(0, 0, 1100, lat);
    chk("sum0_sa0_pass", pass, 0);
    chk("sum0_sa0_err", err_count, 256);
    chk("sum0_sa0_ffv", first_fail_vec, 9'h001);

    // Abort a faulty run at cycle 300, then rerun healthy.
    fault = 1;
    pulse_start(0);
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err", err_count, 0);
    chk("abort_ffv", first_fail_vec, 0);
    chk("abort_vec", {dut_mode, dut_b, dut_a}, 0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", {busy, done}, 0);
    fault = 0;
    pulse_start(0);
    wait_done(0, 0, 1100, lat);
    chk("after_abort_latency", lat, 1024);
    chk("after_abort_pass", pass, 1);

    // SETTLE_CYCLES=3 instance against the delayed model.
    pulse_start(1);
    chk("s3_busy", busy3, 1);
    wait_done(1, 0, 2200, lat);
    chk("s3_latency", lat, 2048);
    chk("s3_pass", pass3, 1);
    chk("s3_err", err_count3, 0);
    chk("s3_ffv", first_fail_vec3, 0);
    chk("s3_busy_end", busy3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
